// File: rtl/iob_axistream_in_if.sv
// CPU iob request/response and AXI-Stream receive signals for iob_axistream_in.
// slave = the peripheral side, master = the CPU/stream source side.
interface iob_axistream_in_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int TDATA_W = 8
);
  logic                  valid;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;
  logic [TDATA_W-1:0]    tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport slave (
    input  valid, address, wdata, wstrb, tdata, tvalid, tlast,
    output rdata, ready, tready
  );

  modport master (
    output valid, address, wdata, wstrb, tdata, tvalid, tlast,
    input  rdata, ready, tready
  );
endinterface

// File: rtl/iob_axistream_in.sv
// AXI-Stream receive FIFO read by the CPU (DATA/STATUS/LEVEL/CTRL); CPU response 1 cycle, never stalls.
// tready drops when full, or while a frame is held if IOB_AXISTREAM_IN_TLAST_STOP_EN is defined.
module iob_axistream_in #(
  parameter int TDATA_W         = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  iob_axistream_in_if.slave io_bus
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
  localparam int PTR_W = FIFO_DEPTH_LOG2;
  localparam int WA_W  = ADDR_W - 2;

  logic [TDATA_W:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [LVL_W-1:0]     r_level;
  logic                 r_underflow;
  logic                 r_ready;
  logic [DATA_W-1:0]    r_rdata;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_frame_hold;
  logic                 w_tready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_flush;
  logic                 w_is_rd;
  logic                 w_is_wr;
  logic [WA_W-1:0]      w_word;
  logic                 w_sel_data;
  logic                 w_sel_status;
  logic                 w_sel_level;
  logic                 w_sel_ctrl;
  logic                 w_uflow_set;
  logic                 w_status_rd;
  logic [TDATA_W:0]     w_head;
  logic [DATA_W-1:0]    w_rdata_nxt;
  logic                 w_unused_ok;

  // full is taken from registered level, so a same-cycle pop never frees a slot early
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LVL_W'(DEPTH));
  assign w_tready = ~w_full & ~w_frame_hold;
  assign w_push   = io_bus.tvalid & w_tready;

  assign w_is_rd      = io_bus.valid & (io_bus.wstrb == '0);
  assign w_is_wr      = io_bus.valid & (io_bus.wstrb != '0);
  assign w_word       = io_bus.address[ADDR_W-1:2];
  assign w_sel_data   = (w_word == WA_W'(0));
  assign w_sel_status = (w_word == WA_W'(1));
  assign w_sel_level  = (w_word == WA_W'(2));
  assign w_sel_ctrl   = (w_word == WA_W'(3));

  assign w_pop       = w_is_rd & w_sel_data & ~w_empty;
  assign w_uflow_set = w_is_rd & w_sel_data & w_empty;
  assign w_status_rd = w_is_rd & w_sel_status;
  assign w_flush     = w_is_wr & w_sel_ctrl & io_bus.wdata[0];

  assign w_head      = r_mem[r_rptr];
  assign w_unused_ok = ^{io_bus.wdata[DATA_W-1:1], io_bus.address[1:0]};

`ifdef IOB_AXISTREAM_IN_TLAST_STOP_EN
  logic r_frame_hold;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_hold <= 1'b0;
    end else if (w_flush) begin
      r_frame_hold <= 1'b0;
    end else if (w_push && io_bus.tlast) begin
      r_frame_hold <= 1'b1;
    end else if (w_pop && w_head[TDATA_W]) begin
      r_frame_hold <= 1'b0;
    end
  end

  assign w_frame_hold = r_frame_hold;
`else
  assign w_frame_hold = 1'b0;
`endif

  always_comb begin
    w_rdata_nxt = '0;
    if (w_is_rd) begin
      if (w_sel_data && !w_empty) begin
        w_rdata_nxt[TDATA_W-1:0] = w_head[TDATA_W-1:0];
        w_rdata_nxt[DATA_W-1]    = w_head[TDATA_W];
      end else if (w_sel_status) begin
        w_rdata_nxt[3:0] = {w_frame_hold, r_underflow, w_full, w_empty};
      end else if (w_sel_level) begin
        w_rdata_nxt = DATA_W'(r_level);
      end
    end
  end

  // flush beats a simultaneous push: the beat is dropped, not written
  always_ff @(posedge i_clk) begin
    if (w_push && !w_flush) begin
      r_mem[r_wptr] <= {io_bus.tlast, io_bus.tdata};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= io_bus.valid;
      r_rdata <= w_rdata_nxt;
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LVL_W'(1);
          2'b01:   r_level <= r_level - LVL_W'(1);
          default: r_level <= r_level;
        endcase
      end
    end
  end

  // the status read returns the sticky bit before clearing it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_underflow <= 1'b0;
    end else if (w_uflow_set) begin
      r_underflow <= 1'b1;
    end else if (w_status_rd) begin
      r_underflow <= 1'b0;
    end
  end

  assign io_bus.tready = w_tready;
  assign io_bus.ready  = r_ready;
  assign io_bus.rdata  = r_rdata;
endmodule

// File: tb/tb_iob_axistream_in.sv
// Directed bench for iob_axistream_in: vector table plus hand-written multi-cycle sequences.
module tb_iob_axistream_in;
  localparam int OP_PUSH = 0;
  localparam int OP_RD   = 1;
  localparam int OP_WR   = 2;

`ifdef IOB_AXISTREAM_IN_TLAST_STOP_EN
  localparam logic [31:0] HOLD_ST = 32'h8;
`else
  localparam logic [31:0] HOLD_ST = 32'h0;
`endif

  typedef struct {
    int          op;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [7:0]  td;
    logic        tl;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  iob_axistream_in_if #(.DATA_W(32), .ADDR_W(4), .TDATA_W(8)) bus ();

  iob_axistream_in #(
    .TDATA_W(8), .FIFO_DEPTH_LOG2(4), .DATA_W(32), .ADDR_W(4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic cpu(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd);
    bus.valid   = 1'b1;
    bus.address = a;
    bus.wdata   = wd;
    bus.wstrb   = ws;
    tick();
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    bus.wdata = 32'h0;
    chk("ready", {31'h0, bus.ready}, 32'h1);
    rd = bus.rdata;
    tick();
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cpu(a, 32'h0, 4'h0, d);
    chk(nm, d, exp);
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    bus.tvalid = 1'b1;
    bus.tdata  = d;
    bus.tlast  = l;
    chk("push_tready", {31'h0, bus.tready}, 32'h1);
    tick();
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] d;
    int k;
    logic acc;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.valid = 1'b0; bus.address = 4'h0; bus.wdata = 32'h0; bus.wstrb = 4'h0;
    bus.tvalid = 1'b0; bus.tdata = 8'h0; bus.tlast = 1'b0;

    tbl.push_back('{OP_RD,   4'h8, 32'h0, 8'h00, 1'b0, 32'h0,        "level_reset"});
    tbl.push_back('{OP_RD,   4'h4, 32'h0, 8'h00, 1'b0, 32'h1,        "status_reset"});
    tbl.push_back('{OP_PUSH, 4'h0, 32'h0, 8'h11, 1'b0, 32'h0,        "push_11"});
    tbl.push_back('{OP_PUSH, 4'h0, 32'h0, 8'h22, 1'b0, 32'h0,        "push_22"});
    tbl.push_back('{OP_PUSH, 4'h0, 32'h0, 8'h33, 1'b1, 32'h0,        "push_33"});
    tbl.push_back('{OP_RD,   4'h8, 32'h0, 8'h00, 1'b0, 32'h3,        "level_3"});
    tbl.push_back('{OP_RD,   4'h4, 32'h0, 8'h00, 1'b0, HOLD_ST,      "status_3"});
    tbl.push_back('{OP_RD,   4'h0, 32'h0, 8'h00, 1'b0, 32'h11,       "data_11"});
    tbl.push_back('{OP_RD,   4'h0, 32'h0, 8'h00, 1'b0, 32'h22,       "data_22"});
    tbl.push_back('{OP_RD,   4'h0, 32'h0, 8'h00, 1'b0, 32'h80000033, "data_33_last"});
    tbl.push_back('{OP_RD,   4'h4, 32'h0, 8'h00, 1'b0, 32'h1,        "status_drained"});
    tbl.push_back('{OP_RD,   4'h0, 32'h0, 8'h00, 1'b0, 32'h0,        "data_empty"});
    tbl.push_back('{OP_RD,   4'h8, 32'h0, 8'h00, 1'b0, 32'h0,        "level_after_uflow"});
    tbl.push_back('{OP_RD,   4'h4, 32'h0, 8'h00, 1'b0, 32'h5,        "status_uflow"});
    tbl.push_back('{OP_RD,   4'h4, 32'h0, 8'h00, 1'b0, 32'h1,        "status_uflow_clr"});
    tbl.push_back('{OP_WR,   4'h0, 32'hFF, 8'h00, 1'b0, 32'h0,       "write_data_ign"});
    tbl.push_back('{OP_RD,   4'hC, 32'h0, 8'h00, 1'b0, 32'h0,        "read_ctrl"});
    tbl.push_back('{OP_PUSH, 4'h0, 32'h0, 8'h5A, 1'b0, 32'h0,        "push_5a"});
    tbl.push_back('{OP_WR,   4'hC, 32'h0, 8'h00, 1'b0, 32'h0,        "ctrl_no_flush"});
    tbl.push_back('{OP_RD,   4'h8, 32'h0, 8'h00, 1'b0, 32'h1,        "level_1"});
    tbl.push_back('{OP_RD,   4'h0, 32'h0, 8'h00, 1'b0, 32'h5A,       "data_5a"});

    // reset held for two edges
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready",  {31'h0, bus.ready},  32'h0);
    chk("rst_rdata",  bus.rdata,           32'h0);
    chk("rst_tready", {31'h0, bus.tready}, 32'h1);

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_PUSH: push(tbl[i].td, tbl[i].tl);
        OP_WR: begin
          cpu(tbl[i].addr, tbl[i].wd, 4'hF, d);
          chk(tbl[i].nm, d, tbl[i].exp);
        end
        default: rd_chk(tbl[i].nm, tbl[i].addr, tbl[i].exp);
      endcase
    end

    // fill with continuous tvalid, then one pop lets beat 0x10 in
    k = 0;
    bus.tvalid = 1'b1;
    for (int cyc = 0; cyc < 60 && k < 16; cyc++) begin
      bus.tdata = k[7:0];
      acc = bus.tready;
      tick();
      if (acc) k++;
    end
    chk("fill_count", k, 16);
    bus.tdata = 8'h10;
    chk("full_tready", {31'h0, bus.tready}, 32'h0);
    rd_chk("level_16", 4'h8, 32'h10);
    rd_chk("status_full", 4'h4, 32'h2);
    bus.valid = 1'b1; bus.address = 4'h0; bus.wstrb = 4'h0;
    tick();
    bus.valid = 1'b0;
    chk("full_pop_ready", {31'h0, bus.ready}, 32'h1);
    chk("full_pop_data", bus.rdata, 32'h0);
    chk("tready_after_pop", {31'h0, bus.tready}, 32'h1);
    tick();
    bus.tvalid = 1'b0;
    chk("tready_refull", {31'h0, bus.tready}, 32'h0);
    chk("ready_idle", {31'h0, bus.ready}, 32'h0);
    chk("rdata_idle", bus.rdata, 32'h0);
    for (int j = 1; j <= 16; j++) rd_chk("drain", 4'h0, j);
    rd_chk("status_after_drain", 4'h4, 32'h1);

    // flush in the same edge as a sixth beat
    for (int j = 0; j < 5; j++) push(8'h40 + j[7:0], 1'b0);
    bus.tvalid = 1'b1; bus.tdata = 8'h45; bus.tlast = 1'b0;
    bus.valid = 1'b1; bus.address = 4'hC; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    tick();
    bus.tvalid = 1'b0; bus.valid = 1'b0; bus.wstrb = 4'h0; bus.wdata = 32'h0;
    chk("flush_ready", {31'h0, bus.ready}, 32'h1);
    tick();
    rd_chk("flush_level", 4'h8, 32'h0);
    rd_chk("flush_status", 4'h4, 32'h1);
    push(8'h46, 1'b0);
    rd_chk("after_flush_data", 4'h0, 32'h46);

    // tlast handling with a follow-on beat already waiting
    push(8'hA0, 1'b0);
    bus.tvalid = 1'b1; bus.tdata = 8'hA1; bus.tlast = 1'b1;
    tick();
    bus.tdata = 8'hB0; bus.tlast = 1'b0;
`ifdef IOB_AXISTREAM_IN_TLAST_STOP_EN
    chk("hold_tready", {31'h0, bus.tready}, 32'h0);
    rd_chk("hold_status", 4'h4, 32'h8);
    rd_chk("hold_pop_a0", 4'h0, 32'hA0);
    chk("hold_tready2", {31'h0, bus.tready}, 32'h0);
    bus.valid = 1'b1; bus.address = 4'h0; bus.wstrb = 4'h0;
    tick();
    bus.valid = 1'b0;
    chk("hold_pop_a1", bus.rdata, 32'h800000A1);
    chk("hold_release", {31'h0, bus.tready}, 32'h1);
    tick();
    bus.tvalid = 1'b0;
    rd_chk("hold_level", 4'h8, 32'h1);
    rd_chk("hold_b0", 4'h0, 32'hB0);
`else
    chk("nohold_tready", {31'h0, bus.tready}, 32'h1);
    tick();
    bus.tvalid = 1'b0;
    rd_chk("nohold_level", 4'h8, 32'h3);
    rd_chk("nohold_a0", 4'h0, 32'hA0);
    rd_chk("nohold_a1", 4'h0, 32'h800000A1);
    rd_chk("nohold_b0", 4'h0, 32'hB0);
`endif
    rd_chk("tlast_status_end", 4'h4, 32'h1);

    // reset arriving together with a request
    push(8'h77, 1'b0);
    push(8'h78, 1'b0);
    bus.valid = 1'b1; bus.address = 4'h8; bus.wstrb = 4'h0;
    rst = 1'b1;
    tick();
    bus.valid = 1'b0;
    chk("midrst_ready", {31'h0, bus.ready}, 32'h0);
    chk("midrst_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    rd_chk("midrst_level", 4'h8, 32'h0);
    rd_chk("midrst_status", 4'h4, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/iob_axistream_in.md
Name: iob_axistream_in

Overview:
AXI-Stream receiver peripheral. It accepts beats (tdata + tlast) from an upstream AXI-Stream source into an internal FIFO and exposes them to the CPU through the iob native slave interface as memory-mapped registers. It is the receive-side counterpart of the stream-out peripheral and sits on the CPU peripheral bus beside it.

Parameters:
TDATA_W, 8, stream data width; legal range 1..DATA_W-1
FIFO_DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 entries by default)
DATA_W, 32, CPU data width
ADDR_W, 4, CPU byte-address width (4 word registers)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
valid  input  1  CPU request strobe, one-cycle pulse
address  input  ADDR_W  CPU byte address
wdata  input  DATA_W  CPU write data
wstrb  input  DATA_W/8  write strobes; all zero means read
rdata  output  DATA_W  CPU read data
ready  output  1  CPU request completion
tdata  input  TDATA_W  stream data
tvalid  input  1  stream beat valid
tready  output  1  stream beat accept
tlast  input  1  stream end-of-frame marker

Behaviour:
- One clock, clk. rst is synchronous and active-high. On reset: FIFO empty, level=0, ready=0, rdata=0, underflow=0, frame_hold=0. tready is 1 in the first cycle after reset is released.
- FIFO: depth 2^FIFO_DEPTH_LOG2, entry width TDATA_W+1 ({tlast,tdata}). Circular read and write pointers wrap modulo depth. Level counter is FIFO_DEPTH_LOG2+1 bits wide (0..depth).
- Stream side:
  - tready = ~full & ~frame_hold, decoded from registered state only, never from tvalid.
  - A beat is accepted at a clock edge where tvalid & tready.
  - full is evaluated before any same-cycle pop. A full FIFO refuses a beat even while a CPU pop occurs that cycle.
- Register map (byte offsets):
  - 0x0 DATA (R): pops one entry. rdata[TDATA_W-1:0]=tdata, rdata[DATA_W-1]=tlast, all other bits 0. If the FIFO is empty: rdata=0, no pop, underflow sticky bit set.
  - 0x4 STATUS (R): bit0=empty, bit1=full, bit2=underflow, bit3=frame_hold, other bits 0. Reading STATUS clears underflow after returning it.
  - 0x8 LEVEL (R): current level, zero-extended.
  - 0xC CTRL (W): wdata[0]=1 flushes (pointers, level and frame_hold to 0; underflow unchanged). Reads of CTRL return 0.
  - Writes to 0x0–0x8 are ignored but still acknowledged. Reads of write-only or undefined fields return 0.
- CPU handshake:
  - A request sampled with valid=1 at edge k gets ready=1 for exactly one cycle after edge k. rdata is valid during that cycle and is 0 otherwise.
  - The CPU issues no new request while a response is pending.
  - Pop, flush and underflow updates take effect at edge k.
- Simultaneous events:
  - Push + pop in the same edge leaves level unchanged; both pointers advance.
  - Push + flush in the same edge: flush wins and the pushed beat is discarded.
  - The accepted beat is visible to a request sampled at the next edge or later.
- Reset asserted mid-operation overrides everything at that edge: the FIFO is emptied and any pending ready is dropped.
- Storage: registers or inferred 2-port RAM with registered write. The read path must present the head entry combinationally or by prefetch so that the DATA read latency stays at 1 cycle.

Optional Feature:
Macro IOB_AXISTREAM_IN_TLAST_STOP_EN.
- Defined: accepting a beat with tlast=1 sets frame_hold, forcing tready=0. frame_hold clears at the edge where the CPU pops the entry carrying tlast=1, or on flush or reset. At most one frame is buffered at a time.
- Undefined: frame_hold is tied to 0, STATUS bit3 reads 0, and tlast is only stored.

Test Plan:
- Reset: assert rst 2 cycles -> tready=1 next cycle, ready=0, rdata=0, LEVEL=0, STATUS=0x1.
- Push 0x11, 0x22, 0x33 (last beat tlast=1) -> LEVEL=3; three DATA reads return 0x00000011, 0x00000022, 0x80000033; then STATUS=0x1.
- Drive tvalid continuously with 17 beats 0x00..0x10 -> tready=0 after the 16th beat, LEVEL=16, STATUS bit1=1. One DATA read returns 0x00, tready=1 the next cycle, and 0x10 is accepted.
- Read DATA when empty -> rdata=0, LEVEL stays 0. STATUS read returns 0x5; the following STATUS read returns 0x1.
- Push 5 beats, then write CTRL=0x1 in the same cycle as a sixth beat -> LEVEL=0, STATUS=0x1, and the sixth beat is not read back.
- With IOB_AXISTREAM_IN_TLAST_STOP_EN: push 0xA0, then 0xA1 with tlast=1, keep tvalid high with 0xB0 -> tready=0 and STATUS=0x8. Pops return 0xA0, then 0x800000A1; 0xB0 is accepted the cycle after the second pop. Without the macro, 0xB0 is accepted immediately.
